key_switch_memory: RTL and testbench
====================================

Name: key_switch_memory

Overview:
- Memory-mapped input peripheral on the CPU data bus; the input-side counterpart to the LED/7-segment output register.
- Samples the board slide switches and push buttons, then synchronizes and debounces them.
- Exposes the stable levels and sticky button-press flags to load instructions; press flags are cleared by stores.
- The external address decoder asserts KeyMemoryRd/KeyMemoryWr; this block decodes only the word offset.

Parameters:
NUM_SW, 8, number of slide switch inputs (1..16)
NUM_BTN, 4, number of push button inputs (1..16)
DEBOUNCE_CYCLES, 100000, consecutive clk cycles a changed input must hold before it is accepted (>=2)
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-low
addr  in  32  byte address; only addr[2] used (0: level register, 1: press-flag register)
data_in  in  32  store data
data_out  out  32  load data
KeyMemoryWr  in  1  store strobe, one cycle
KeyMemoryRd  in  1  load enable
sw_in  in  NUM_SW  raw asynchronous switch pins
btn_in  in  NUM_BTN  raw asynchronous button pins, 1 = pressed

Behaviour:
- Reset (rst low, asynchronous): both synchronizer stages, stable levels, counters and press flags are 0. data_out follows the combinational rule below; with Rd=0 it is 0.
- Synchronizer: each input passes through two flops (sync1 -> sync2). There is no logic between the stages.
- Debounce, per input, independent:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Otherwise: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (at sync2) never changes stable. It restarts the count from 0 when it returns.
- Latency: a raw pin step that holds produces a stable change at the 2+DEBOUNCE_CYCLES-th rising edge after the pin change (2 sync + DEBOUNCE_CYCLES count).
- Press flags:
  - flag[i] <= 1 on the cycle btn stable[i] goes 0->1. Release (1->0) sets nothing.
  - Flags are sticky until cleared.
- Register map, word offset = addr[2]:
  - Offset 0 (0x0), read-only. Bits [NUM_SW-1:0] = stable switches. Bits [NUM_SW+NUM_BTN-1:NUM_SW] = stable buttons. Remaining bits read 0. Stores to offset 0 are ignored.
  - Offset 1 (0x4), read/write-1-to-clear. Bits [NUM_BTN-1:0] = press flags. On KeyMemoryWr at offset 1, flag[i] <= 0 where data_in[i]=1; other data_in bits are ignored.
- Read path: data_out = KeyMemoryRd ? selected register (zero-extended) : 32'h0. It is combinational, with zero-latency load data.
- Simultaneous events:
  - A press edge on the same cycle as a W1C to that bit: set wins, flag = 1.
  - Read and write on the same cycle: the read returns the pre-write value.
- Rd and Wr both low: all registers hold; the debounce logic keeps running.
- Reset mid-debounce: the count is lost. After release, a pin held high is re-accepted after a full 2+DEBOUNCE_CYCLES cycles, which also sets its flag.
- addr bits other than [2] do not affect behaviour.

Decomposition:
- Shared package key_switch_pkg: localparams KEY_OFS_LEVEL = 1'b0, KEY_OFS_FLAG = 1'b1, and KEY_REG_W = 32.
- Sub-module debounce_cell:
  - Params: DEBOUNCE_CYCLES, CNT_W.
  - Ports: clk, rst, raw_in, stable_out, rise_pulse.
  - Contents: the 2-flop synchronizer, the counter and a one-cycle 0->1 pulse.
  - Instantiated NUM_SW+NUM_BTN times via generate.
- Top-level contents: flag registers, W1C logic and the read mux.

Test Plan (DEBOUNCE_CYCLES overridden to 4; NUM_SW=8, NUM_BTN=4):
- Reset -> with rst low, any pin pattern and Rd=1, addr=0x0 reads 32'h0. Release rst with sw_in=8'hA5 held -> offset 0 reads 32'h000000A5 from edge 6 after release, and 0 before.
- Glitch rejection -> btn_in[0] high for 3 cycles then low -> offset 0 bit 8 stays 0 and offset 1 reads 32'h0. Held 10 cycles -> bit 8 = 1 at edge 6 and offset 1 reads 32'h1.
- Sticky/W1C -> press btn 1 and btn 3, then release both -> offset 1 reads 32'hA. Store data_in=32'h2 at 0x4 -> reads 32'h8. Store 32'hFFFFFFFF -> reads 32'h0.
- Set-vs-clear collision -> schedule a W1C of bit 2 on the exact cycle btn 2's stable rises -> offset 1 bit 2 reads 1 afterward.
- Store to offset 0 with data_in=32'hFFFFFFFF -> level and flag registers unchanged. With KeyMemoryRd=0 -> data_out = 32'h0 regardless of addr.
- Async reset mid-operation -> assert rst between clock edges while flags = 4'hF and a count is in progress -> flags and levels read 0 immediately (before the next edge). After release with btn 0 held -> flag bit 0 returns after 6 edges.

Source files
------------

// File: rtl/key_switch_pkg.sv
// Shared register-map constants for the key/switch input peripheral.
package key_switch_pkg;
    localparam logic KEY_OFS_LEVEL = 1'b0;
    localparam logic KEY_OFS_FLAG  = 1'b1;
    localparam int   KEY_REG_W     = 32;
endpackage

// File: rtl/debounce_cell.sv
// One input channel: two-flop synchronizer, hold-time debounce counter and a
// one-cycle pulse coincident with the stable level's 0->1 transition.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_pulse
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept     = (sync2 != stable_out) && (cnt == CNT_MAX);
    // Asserted in the cycle whose edge raises stable_out, so a flag set by it
    // lands on the same edge as the level.
    assign rise_pulse = accept & sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_out <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (sync2 == stable_out) begin
                cnt <= '0;
            end else if (accept) begin
                stable_out <= sync2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_switch_memory.sv
// Memory-mapped switch/button input port: debounced levels at offset 0,
// sticky write-1-to-clear button press flags at offset 1.
module key_switch_memory
    import key_switch_pkg::*;
#(
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    input  logic                 KeyMemoryWr,
    input  logic                 KeyMemoryRd,
    input  logic [NUM_SW-1:0]    sw_in,
    input  logic [NUM_BTN-1:0]   btn_in
);
    localparam int NUM_IN = NUM_SW + NUM_BTN;

    logic [NUM_IN-1:0]  raw;
    logic [NUM_IN-1:0]  levels;
    logic [NUM_IN-1:0]  rise;
    logic [NUM_BTN-1:0] flags;
    logic [NUM_BTN-1:0] clr;
    logic               unused_bits;

    assign raw = {btn_in, sw_in};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .raw_in    (raw[g]),
            .stable_out(levels[g]),
            .rise_pulse(rise[g])
        );
    end

    assign clr = (KeyMemoryWr && addr[2] == KEY_OFS_FLAG) ? data_in[NUM_BTN-1:0] : '0;

    // Set is ORed in after the clear so a press edge beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags <= '0;
        else      flags <= (flags & ~clr) | rise[NUM_IN-1:NUM_SW];
    end

    always_comb begin
        data_out = '0;
        if (KeyMemoryRd) begin
            if (addr[2] == KEY_OFS_LEVEL) data_out = KEY_REG_W'(levels);
            else                          data_out = KEY_REG_W'(flags);
        end
    end

    assign unused_bits = ^{addr[31:3], addr[1:0], data_in[31:NUM_BTN], rise[NUM_SW-1:0]};
endmodule

// File: tb/tb_key_switch_memory.sv
// Directed bench for key_switch_memory with a 4-cycle debounce window.
module tb_key_switch_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        KeyMemoryWr;
    logic        KeyMemoryRd;
    logic [7:0]  sw_in;
    logic [3:0]  btn_in;

    int n_assert = 0;
    int n_fail   = 0;

    key_switch_memory #(
        .NUM_SW(8), .NUM_BTN(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
        .KeyMemoryWr(KeyMemoryWr), .KeyMemoryRd(KeyMemoryRd),
        .sw_in(sw_in), .btn_in(btn_in)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr        = a;
        KeyMemoryRd = 1'b1;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr        = a;
        data_in     = d;
        KeyMemoryWr = 1'b1;
        tick(1);
        KeyMemoryWr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; addr = '0; data_in = '0; KeyMemoryWr = 1'b0; KeyMemoryRd = 1'b1;
        sw_in = 8'h5A; btn_in = 4'hF;
        @(negedge clk);
        tick(2);
        rd_check("reset_lvl", 32'h0, 32'h0);
        rd_check("reset_flg", 32'h4, 32'h0);

        // Release with switches held: level appears on the 6th edge
        sw_in = 8'hA5; btn_in = 4'h0;
        rst = 1'b1;
        tick(5);
        rd_check("sw_edge5", 32'h0, 32'h0);
        tick(1);
        rd_check("sw_edge6", 32'h0, 32'hA5);

        // 3-cycle glitch on btn 0 is rejected
        btn_in = 4'h1;
        tick(3);
        btn_in = 4'h0;
        tick(10);
        rd_check("glitch_lvl", 32'h0, 32'hA5);
        rd_check("glitch_flg", 32'h4, 32'h0);

        // Held press accepted on edge 6
        btn_in = 4'h1;
        tick(5);
        rd_check("btn0_edge5", 32'h0, 32'hA5);
        tick(1);
        rd_check("btn0_edge6", 32'h0, 32'h1A5);
        rd_check("btn0_flag", 32'h4, 32'h1);
        btn_in = 4'h0;
        tick(6);
        rd_check("btn0_release", 32'h0, 32'hA5);
        rd_check("btn0_sticky", 32'h4, 32'h1);
        wr(32'h4, 32'h1);
        rd_check("btn0_clear", 32'h4, 32'h0);

        // Sticky flags on buttons 1 and 3
        btn_in = 4'hA;
        tick(6);
        rd_check("b13_lvl", 32'h0, 32'hAA5);
        btn_in = 4'h0;
        tick(6);
        rd_check("b13_rel_lvl", 32'h0, 32'hA5);
        rd_check("b13_flags", 32'h4, 32'hA);
        addr = 32'h4; data_in = 32'h2; KeyMemoryWr = 1'b1; KeyMemoryRd = 1'b1;
        #1;
        check("rd_during_wr", data_out, 32'hA);
        tick(1);
        KeyMemoryWr = 1'b0;
        rd_check("w1c_bit1", 32'h4, 32'h8);
        wr(32'h4, 32'hFFFFFFFF);
        rd_check("w1c_all", 32'h4, 32'h0);

        // W1C of bit 2 on the same edge that its stable level rises
        btn_in = 4'h4;
        tick(5);
        rd_check("b2_pre_flag", 32'h4, 32'h0);
        wr(32'h4, 32'h4);
        rd_check("collision_set_wins", 32'h4, 32'h4);
        rd_check("collision_lvl", 32'h0, 32'h4A5);
        wr(32'h4, 32'h4);
        rd_check("b2_clear_held", 32'h4, 32'h0);
        btn_in = 4'h0;
        tick(6);

        // Stores to offset 0 are ignored
        btn_in = 4'hF;
        tick(6);
        btn_in = 4'h0;
        tick(6);
        rd_check("all_flags", 32'h4, 32'hF);
        wr(32'h0, 32'hFFFFFFFF);
        rd_check("st0_lvl", 32'h0, 32'hA5);
        rd_check("st0_flg", 32'h4, 32'hF);
        rd_check("addr_hi_ignored", 32'hFFFF_FFF4, 32'hF);
        KeyMemoryRd = 1'b0;
        addr = 32'h4; #1;
        check("rd0_ofs1", data_out, 32'h0);
        addr = 32'h0; #1;
        check("rd0_ofs0", data_out, 32'h0);
        KeyMemoryRd = 1'b1;

        // Async reset between edges while a count is in progress
        @(negedge clk);
        btn_in = 4'h1;
        tick(3);
        #1;
        rst = 1'b0;
        #1;
        addr = 32'h4; #1;
        check("async_flg", data_out, 32'h0);
        addr = 32'h0; #1;
        check("async_lvl", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(5);
        rd_check("rerun_edge5", 32'h4, 32'h0);
        tick(1);
        rd_check("rerun_edge6_flg", 32'h4, 32'h1);
        rd_check("rerun_edge6_lvl", 32'h0, 32'h1A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
